spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 170 +++++++++++++++++
 tb/tb_spi_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 controller: one MSB-first byte per accepted start, with optional
// chip-select hold so consecutive bytes share a single CS-low frame.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       hold_cs,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       SCK,
    output logic       CS,
    output logic       COPI,
    input  logic       CIPO,
    output logic [2:0] dbg_state
);

    // Handshake: start is taken on a rising clk edge only when the FSM is in
    // IDLE with busy=0; tx_byte and that start are sampled on the same edge.
    // busy is high from the next cycle until (not including) the rx_valid cycle.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_TRAIL = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [6:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       sck_q, sck_d;
    logic       cs_q, cs_d;
    logic       copi_q, copi_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;

    logic div_done;
    logic accept;

    assign div_done = (div_q == DIV_LAST);
    assign accept   = (state_q == S_IDLE) && start && !busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)   state_d = S_LEAD;
            S_LEAD:  if (div_done) state_d = S_HIGH;
            S_HIGH:  if (div_done) state_d = (bit_q == 3'd7) ? S_TRAIL : S_LOW;
            S_LOW:   if (div_done) state_d = S_HIGH;
            S_TRAIL: if (div_done) state_d = hold_cs ? S_IDLE : S_GAP;
            S_GAP:   if (div_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of every registered output and datapath register.
    always_comb begin
        sck_d      = sck_q;
        cs_d       = cs_q;
        copi_d     = copi_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        bit_d      = bit_q;

        // The divider restarts on every state change, so it never passes DIV_LAST.
        if (state_d != state_q || state_q == S_IDLE) begin
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tx_sh_d = tx_byte[6:0];
                    copi_d  = tx_byte[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 3'd0;
                end else if (cs_q) begin
                    copi_d = 1'b0;
                end
            end
            S_LEAD, S_LOW: begin
                if (div_done) begin
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], CIPO};
                end
            end
            S_HIGH: begin
                if (div_done) begin
                    sck_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        copi_d  = tx_sh_q[6];
                        tx_sh_d = {tx_sh_q[5:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_TRAIL: begin
                if (div_done) begin
                    rx_byte_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    busy_d     = 1'b0;
                    if (!hold_cs) begin
                        cs_d   = 1'b1;
                        copi_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_sh_q    <= 7'd0;
            rx_sh_q    <= 8'd0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            copi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            copi_q     <= copi_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    assign SCK       = sck_q;
    assign CS        = cs_q;
    assign COPI      = copi_q;
    assign busy      = busy_q;
    assign rx_valid  = rx_valid_q;
    assign rx_byte   = rx_byte_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: fast instance (CLK_DIV=4) with loopback or a
// behavioural peripheral, plus a slow instance (CLK_DIV=255) with CIPO tied high.
module tb_spi_controller;

    localparam int DIV  = 4;
    localparam int SDIV = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       hold_cs = 1'b0;
    logic       busy, rx_valid, sck, cs, copi, cipo;
    logic [7:0] rx_byte;
    logic [2:0] dbg_state;

    logic       start_s = 1'b0;
    logic [7:0] tx_s = 8'h00;
    logic       busy_s, rx_valid_s, sck_s, cs_s, copi_s;
    logic [7:0] rx_byte_s;
    logic [2:0] dbg_state_s;

    logic       loop_mode = 1'b1;
    logic [7:0] periph_byte = 8'h00;
    logic [7:0] psh = 8'h00;
    int         pbit = 0;

    assign cipo = loop_mode ? copi : psh[7];

    spi_controller #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_byte(tx_byte), .hold_cs(hold_cs),
        .busy(busy), .rx_byte(rx_byte), .rx_valid(rx_valid), .SCK(sck), .CS(cs),
        .COPI(copi), .CIPO(cipo), .dbg_state(dbg_state)
    );

    spi_controller #(.CLK_DIV(SDIV)) dut_slow (
        .clk(clk), .rst_n(rst_n), .start(start_s), .tx_byte(tx_s), .hold_cs(1'b0),
        .busy(busy_s), .rx_byte(rx_byte_s), .rx_valid(rx_valid_s), .SCK(sck_s), .CS(cs_s),
        .COPI(copi_s), .CIPO(1'b1), .dbg_state(dbg_state_s)
    );

    int errors = 0;
    int checks = 0;
    int pcnt = 0;
    int acc_p = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_seen[$];

    // monitor of the fast instance
    logic        sck_prev = 1'b0;
    int          rises, falls, run, hi_min, hi_max, lo_min, lo_max;
    int          cs_low, rxv_cnt, first_rise_p;
    logic [15:0] copi_obs;

    // monitor of the slow instance
    logic sck_prev_s = 1'b0;
    int   rises_s, falls_s, run_s, hi_min_s, hi_max_s, lo_min_s, lo_max_s, rxv_s;

    always @(posedge clk) pcnt++;

    always @(negedge clk) begin
        logic rose, fell;
        rose = sck && !sck_prev;
        fell = !sck && sck_prev;
        if (rose) begin
            if (rises == 0) first_rise_p = pcnt;
            if (falls > 0) begin
                if (run < lo_min) lo_min = run;
                if (run > lo_max) lo_max = run;
            end
            rises++;
            copi_obs = {copi_obs[14:0], copi};
            run = 1;
        end else if (fell) begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
            falls++;
            run = 1;
        end else begin
            run++;
        end
        sck_prev = sck;
        if (!cs) cs_low++;
        if (rx_valid) begin
            rxv_cnt++;
            rx_seen.push_back(rx_byte);
        end
        // peripheral: presents MSB while CS high, next bit after each SCK fall
        if (cs) begin
            pbit = 0;
            psh  = periph_byte;
        end else if (fell) begin
            pbit++;
            if (pbit == 8) begin
                pbit = 0;
                psh  = periph_byte;
            end else begin
                psh = {psh[6:0], 1'b0};
            end
        end
    end

    always @(negedge clk) begin
        logic rose, fell;
        rose = sck_s && !sck_prev_s;
        fell = !sck_s && sck_prev_s;
        if (rose) begin
            if (falls_s > 0) begin
                if (run_s < lo_min_s) lo_min_s = run_s;
                if (run_s > lo_max_s) lo_max_s = run_s;
            end
            rises_s++;
            run_s = 1;
        end else if (fell) begin
            if (run_s < hi_min_s) hi_min_s = run_s;
            if (run_s > hi_max_s) hi_max_s = run_s;
            falls_s++;
            run_s = 1;
        end else begin
            run_s++;
        end
        sck_prev_s = sck_s;
        if (rx_valid_s) rxv_s++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rises = 0; falls = 0; run = 0;
        hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
        cs_low = 0; rxv_cnt = 0; first_rise_p = -1; copi_obs = 16'h0;
        rx_seen.delete();
    endtask

    task automatic clear_mon_s();
        rises_s = 0; falls_s = 0; run_s = 0;
        hi_min_s = 1 << 30; hi_max_s = 0; lo_min_s = 1 << 30; lo_max_s = 0; rxv_s = 0;
    endtask

    task automatic start_xfer(input logic [7:0] b, input logic h);
        tick();
        tx_byte = b;
        hold_cs = h;
        start = 1'b1;
        tick();
        start = 1'b0;
        acc_p = pcnt;
    endtask

    task automatic wait_rx(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_rx: no rx_valid within %0d cycles, state %0d", max_cyc, dbg_state);
        end
    endtask

    task automatic wait_rises(input int n, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (rises >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_rises: saw %0d rising SCK edges, wanted %0d", rises, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", sck); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", cs); end
        checks++; if (copi !== 1'b0) begin errors++; $display("FAIL reset_copi: got %b want 0", copi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
        checks++; if (cs_s !== 1'b1 || sck_s !== 1'b0) begin errors++; $display("FAIL reset_slow: got cs=%b sck=%b want 1 0", cs_s, sck_s); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        bit ok;
        loop_mode = 1'b1;
        clear_mon();
        start_xfer(8'hA5, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy_on: got %b want 1", busy); end
        checks++; if (cs !== 1'b0) begin errors++; $display("FAIL loop_cs_on: got %b want 0", cs); end
        wait_rx(200, ok);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy_at_valid: got %b want 0", busy); end
        checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL loop_rx_byte: got %h want a5", rx_byte); end
        repeat (DIV + 2) tick();
        checks++; if (rises != 8 || falls != 8) begin errors++; $display("FAIL loop_edges: got %0d/%0d want 8/8", rises, falls); end
        checks++; if (hi_min != DIV || hi_max != DIV) begin errors++; $display("FAIL loop_high_len: got %0d..%0d want %0d", hi_min, hi_max, DIV); end
        checks++; if (lo_min != DIV || lo_max != DIV) begin errors++; $display("FAIL loop_low_len: got %0d..%0d want %0d", lo_min, lo_max, DIV); end
        checks++; if (first_rise_p - acc_p != DIV) begin errors++; $display("FAIL loop_first_rise: got %0d want %0d", first_rise_p - acc_p, DIV); end
        checks++; if (cs_low != DIV * 17) begin errors++; $display("FAIL loop_cs_low: got %0d want %0d", cs_low, DIV * 17); end
        checks++; if (rxv_cnt != 1) begin errors++; $display("FAIL loop_rx_valid_cnt: got %0d want 1", rxv_cnt); end
        checks++; if (copi_obs[7:0] !== 8'hA5) begin errors++; $display("FAIL loop_copi_stream: got %h want a5", copi_obs[7:0]); end
        checks++; if (cs !== 1'b1 || copi !== 1'b0) begin errors++; $display("FAIL loop_idle_lines: got cs=%b copi=%b want 1 0", cs, copi); end
    endtask

    task automatic test_peripheral();
        bit ok;
        logic [7:0] t, exp;
        loop_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            t = (i == 0) ? 8'hC3 : 8'($urandom_range(0, 255));
            periph_byte = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            exp_q.push_back(periph_byte);
            clear_mon();
            start_xfer(t, 1'b0);
            wait_rx(200, ok);
            repeat (DIV + 2) tick();
            exp = exp_q.pop_front();
            checks++;
            if (rx_seen.size() != 1) begin
                errors++; $display("FAIL periph_rx_count[%0d]: got %0d want 1", i, rx_seen.size());
            end else if (rx_seen[0] !== exp) begin
                errors++; $display("FAIL periph_rx_byte[%0d]: got %h want %h", i, rx_seen[0], exp);
            end
            checks++; if (copi_obs[7:0] !== t) begin errors++; $display("FAIL periph_copi[%0d]: got %h want %h", i, copi_obs[7:0], t); end
        end
        loop_mode = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp;
        loop_mode = 1'b1;
        clear_mon();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        start_xfer(8'h01, 1'b0);
        repeat (10) tick();
        hold_cs = 1'b1;
        wait_rx(200, ok);
        checks++; if (cs !== 1'b0) begin errors++; $display("FAIL b2b_cs_held: got %b want 0", cs); end
        tx_byte = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_second: got %b want 1", busy); end
        repeat (10) tick();
        hold_cs = 1'b0;
        wait_rx(200, ok);
        repeat (DIV + 2) tick();
        checks++; if (rxv_cnt != 2) begin errors++; $display("FAIL b2b_rx_valid_cnt: got %0d want 2", rxv_cnt); end
        checks++; if (rises != 16) begin errors++; $display("FAIL b2b_rises: got %0d want 16", rises); end
        checks++; if (cs_low != 2 * DIV * 17 + 1) begin errors++; $display("FAIL b2b_cs_low: got %0d want %0d", cs_low, 2 * DIV * 17 + 1); end
        checks++; if (copi_obs !== 16'h0102) begin errors++; $display("FAIL b2b_copi: got %h want 0102", copi_obs); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL b2b_cs_released: got %b want 1", cs); end
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (i >= rx_seen.size()) begin
                errors++; $display("FAIL b2b_rx_missing[%0d]: got none want %h", i, exp);
            end else if (rx_seen[i] !== exp) begin
                errors++; $display("FAIL b2b_rx_byte[%0d]: got %h want %h", i, rx_seen[i], exp);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [7:0] t1, t2;
        loop_mode = 1'b1;
        t1 = 8'($urandom_range(0, 255));
        t2 = ~t1;
        clear_mon();
        start_xfer(t1, 1'b0);
        wait_rises(4, 200);
        tx_byte = t2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
        wait_rx(200, ok);
        checks++; if (rx_byte !== t1) begin errors++; $display("FAIL ign_rx_byte: got %h want %h", rx_byte, t1); end
        checks++; if (copi_obs[7:0] !== t1) begin errors++; $display("FAIL ign_copi: got %h want %h", copi_obs[7:0], t1); end
        // this cycle is the CS-high gap; a start here must be dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_mon();
        repeat (3 * DIV) tick();
        checks++; if (rises != 0 || cs_low != 0) begin errors++; $display("FAIL gap_start_dropped: got rises=%0d cs_low=%0d want 0 0", rises, cs_low); end
        checks++; if (busy !== 1'b0 || cs !== 1'b1) begin errors++; $display("FAIL gap_idle: got busy=%b cs=%b want 0 1", busy, cs); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] t;
        loop_mode = 1'b1;
        clear_mon();
        start_xfer(8'h96, 1'b0);
        wait_rises(5, 200);
        rst_n = 1'b0;
        tick();
        checks++; if (cs !== 1'b1 || sck !== 1'b0) begin errors++; $display("FAIL rstmid_lines: got cs=%b sck=%b want 1 0", cs, sck); end
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b rx_valid=%b want 0 0", busy, rx_valid); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_rx_byte: got %h want 00", rx_byte); end
        rst_n = 1'b1;
        repeat (20 * DIV) tick();
        checks++; if (rxv_cnt != 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d want 0", rxv_cnt); end
        t = 8'($urandom_range(0, 255));
        clear_mon();
        start_xfer(t, 1'b0);
        wait_rx(200, ok);
        checks++; if (rx_byte !== t) begin errors++; $display("FAIL rstmid_restart: got %h want %h", rx_byte, t); end
        repeat (DIV + 2) tick();
        checks++; if (rxv_cnt != 1 || rises != 8) begin errors++; $display("FAIL rstmid_restart_shape: got valid=%0d rises=%0d want 1 8", rxv_cnt, rises); end
    endtask

    task automatic test_slow_divider();
        bit ok;
        clear_mon_s();
        tick();
        tx_s = 8'($urandom_range(0, 255));
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (rx_valid_s) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL slow_timeout: no rx_valid within 6000 cycles, state %0d", dbg_state_s); end
        checks++; if (rx_byte_s !== 8'hFF) begin errors++; $display("FAIL slow_rx_byte: got %h want ff", rx_byte_s); end
        repeat (SDIV + 2) tick();
        checks++; if (rises_s != 8 || falls_s != 8) begin errors++; $display("FAIL slow_edges: got %0d/%0d want 8/8", rises_s, falls_s); end
        checks++; if (hi_min_s != SDIV || hi_max_s != SDIV) begin errors++; $display("FAIL slow_high_len: got %0d..%0d want %0d", hi_min_s, hi_max_s, SDIV); end
        checks++; if (lo_min_s != SDIV || lo_max_s != SDIV) begin errors++; $display("FAIL slow_low_len: got %0d..%0d want %0d", lo_min_s, lo_max_s, SDIV); end
        checks++; if (rxv_s != 1 || cs_s !== 1'b1) begin errors++; $display("FAIL slow_end: got valid=%0d cs=%b want 1 1", rxv_s, cs_s); end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, state %0d", dbg_state);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        clear_mon_s();
        test_reset();
        test_loopback();
        test_peripheral();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_slow_divider();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
